// File: rtl/inst_ram_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction RAM as one-cycle strobes and holds the CPU until done.
module inst_ram_loader #(
    parameter logic [15:0] BASE_ADDR     = 16'h0000,
    parameter logic [15:0] MAX_WORDS     = 16'd1024,
    parameter logic [7:0]  RELEASE_DELAY = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        debug,
    output logic        cpu_reset,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [15:0] inst_ram_write_address,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_GAP,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      r_state;
    logic [15:0] r_word_total;
    logic [15:0] r_word_count;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_assembly;
    logic [7:0]  r_delay;

    logic        r_debug;
    logic        r_cpu_reset;
    logic        r_write_enable;
    logic [31:0] r_write_data;
    logic [15:0] r_write_address;
    logic        r_done;
    logic        r_error;

    logic        w_in_ready;
    logic        w_xfer;
    logic [15:0] w_header;
    logic [15:0] w_count_next;

    // Ready depends on state only, so no combinational path runs from in_valid back out.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_HDR0, S_HDR1, S_DATA: w_in_ready = 1'b1;
            default:                w_in_ready = 1'b0;
        endcase
    end

    assign w_xfer       = in_valid && w_in_ready;
    assign w_header     = {in_data, r_word_total[7:0]};
    assign w_count_next = r_word_count + 16'd1;

    // NOTE: every register here is assigned with <= so all updates on an edge see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_word_total    <= '0;
            r_word_count    <= '0;
            r_byte_idx      <= '0;
            r_assembly      <= '0;
            r_delay         <= '0;
            r_debug         <= 1'b1;
            r_cpu_reset     <= 1'b1;
            r_write_enable  <= 1'b0;
            r_write_data    <= '0;
            r_write_address <= BASE_ADDR;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_HDR0;

                S_HDR0: begin
                    if (w_xfer) begin
                        r_word_total[7:0] <= in_data;
                        r_state           <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (w_xfer) begin
                        r_word_total[15:8] <= in_data;
                        r_word_count       <= '0;
                        r_byte_idx         <= '0;
                        r_delay            <= '0;
                        if (w_header == 16'd0) begin
                            r_state <= S_HOLD;
                        end else if (w_header > MAX_WORDS) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_assembly[7:0]   <= in_data;
                            2'd1: r_assembly[15:8]  <= in_data;
                            2'd2: r_assembly[23:16] <= in_data;
                            default: begin
                                // The top lane bypasses the assembly register straight into the write word.
                                r_write_enable  <= 1'b1;
                                r_write_data    <= {in_data, r_assembly};
                                r_write_address <= BASE_ADDR + r_word_count;
                                r_state         <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: r_state <= S_GAP;

                S_GAP: begin
                    r_word_count <= w_count_next;
                    r_byte_idx   <= '0;
                    r_delay      <= '0;
                    if (w_count_next == r_word_total) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_DATA;
                    end
                end

                S_HOLD: begin
                    if (r_delay == RELEASE_DELAY) begin
                        r_state     <= S_RUN;
                        r_debug     <= 1'b0;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_delay <= r_delay + 8'd1;
                    end
                end

                S_RUN: begin
                    if (reload) begin
                        r_state         <= S_IDLE;
                        r_debug         <= 1'b1;
                        r_cpu_reset     <= 1'b1;
                        r_done          <= 1'b0;
                        r_write_address <= BASE_ADDR;
                        r_word_total    <= '0;
                        r_word_count    <= '0;
                        r_byte_idx      <= '0;
                        r_delay         <= '0;
                    end
                end

                // A rejected header is terminal until the next hardware reset.
                S_ERROR: r_state <= S_ERROR;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready               = w_in_ready;
    assign debug                  = r_debug;
    assign cpu_reset              = r_cpu_reset;
    assign inst_ram_write_enable  = r_write_enable;
    assign inst_ram_write_data    = r_write_data;
    assign inst_ram_write_address = r_write_address;
    assign done                   = r_done;
    assign error                  = r_error;

endmodule
